rsnn_param_serializer: RTL and testbench
========================================

# rsnn_param_serializer

Host-side transmitter for the RSNN serial parameter-load port. It accepts parameter bytes over a valid/ready stream and serializes them MSB-first onto the `load_params`/`data_in` pair of the RSNN core. After each byte it waits for the core's `data_written` acknowledge. After the final byte it waits for `end_writing`, then reports completion or a timeout error. It sits in test/bring-up logic, facing the RSNN top module's parameter port.

## Interface
- `WORD_W`, default 8: bits per parameter word.
- `ACK_TIMEOUT`, default 64: maximum cycles to wait for `data_written` or `end_writing`.
- `clk` in 1: single clock; all logic rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: block enable; when low, FSM holds state and outputs freeze.
- `word_valid` in 1: input word available.
- `word_data` in WORD_W: parameter word.
- `word_last` in 1: marks the final word of the parameter image.
- `word_ready` out 1: word accepted when `word_valid & word_ready`.
- `load_params` out 1: serial strobe; the core samples `data_in` on each edge where this is high.
- `data_out` out 1: serial bit, wired to the core's `data_in`.
- `data_written` in 1: single-cycle per-word acknowledge from the core.
- `end_writing` in 1: level from the core, high once the full image is stored.
- `busy` out 1: FSM not in IDLE.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: sticky timeout flag; cleared only by reset or by the next accepted word.

## Operation
- States: IDLE, SHIFT, WAIT_ACK, WAIT_END, DONE, ERROR.
- IDLE:
  - `word_ready=1`.
  - On handshake: load `word_data` into the shift register, latch `word_last`, clear `bit_cnt`, clear `error`, go to SHIFT.
- SHIFT:
  - `load_params=1`, `data_out=shreg[WORD_W-1]`.
  - Shift left each cycle.
  - After WORD_W cycles, clear the timeout counter and go to WAIT_ACK.
- WAIT_ACK:
  - `load_params=0`, `data_out=0`.
  - On `data_written`: go to WAIT_END if the latched last flag is set, otherwise go to IDLE.
  - If the counter reaches ACK_TIMEOUT-1 without `data_written`: go to ERROR.
- WAIT_END:
  - On `end_writing=1`: go to DONE.
  - On timeout as above: go to ERROR.
- DONE: assert `done` for 1 cycle, then go to IDLE.
- ERROR:
  - Set `error`, go to IDLE.
  - The caller re-streams from word 0.
- `word_ready` is 0 in every state other than IDLE.
- Widths:
  - `bit_cnt` is clog2(WORD_W+1) bits.
  - The timeout counter is clog2(ACK_TIMEOUT) bits and saturates; it never wraps.
- `enable` low: every register holds, `load_params` is forced to 0, and a shift in progress resumes seamlessly when `enable` returns high. The timeout counter also does not advance.
- `data_written` seen outside WAIT_ACK is ignored.
- `end_writing` already high on entry to WAIT_END is accepted in the first cycle.

## Timing
- Reset values: state=IDLE, `word_ready=1`, `load_params=0`, `data_out=0`, `busy=0`, `done=0`, `error=0`, shreg=0, counters=0.
- All outputs are registered, so there are no combinational input-to-output paths.
- Handshake cycle is cycle 0. The first bit appears on `data_out` with `load_params=1` in cycle 1. The last bit appears in cycle WORD_W.
- Minimum word period is WORD_W+2 cycles: WORD_W shift cycles, 1 ack cycle with an immediate ack, and 1 IDLE cycle.
- `done` rises 1 cycle after `end_writing` is sampled. `busy` falls in the same cycle as `done`.
- Asserting reset mid-SHIFT drops `load_params` immediately (asynchronous). A partial word is not completed.

## Structure
- The shared package `rsnn_pkg` holds:
  - the FSM state enum `ser_state_t`;
  - the default constants `RSNN_PARAM_WORD_W=8` and `RSNN_ACK_TIMEOUT=64`.
- Sub-module `rsnn_timeout_ctr`: saturating counter with `clear`, `en` and `expired` ports. It is instantiated once and reused by both wait states.

## Test plan
- Single word 0xA5 with `word_last=1`; `data_written` pulses at cycle 10 and `end_writing` rises at cycle 12:
  - `data_out` shows 1,0,1,0,0,1,0,1 in cycles 1–8 with `load_params` high;
  - `done` pulses one cycle after `end_writing` is sampled;
  - `error=0`.
- Three words 0x01, 0xFF, 0x80 back-to-back, with immediate acks:
  - 24 strobed bits in the correct order;
  - `word_ready` low during each SHIFT and WAIT_ACK;
  - there is exactly 1 IDLE cycle between words.
- No `data_written` after 0x3C:
  - `error` is set after 64 WAIT_ACK cycles;
  - `busy` then falls;
  - the next accepted word clears `error`.
- Drop `enable` for 5 cycles during bit 3 of 0xC3:
  - `load_params=0` while `enable` is low;
  - the bit sequence resumes intact;
  - the timeout counter does not advance.
- Assert reset asynchronously during bit 5:
  - `load_params` and `data_out` go to 0 immediately;
  - the state returns to IDLE with `word_ready=1`.
- `end_writing` already high before the last ack: `done` pulses 2 cycles after the `data_written` pulse (1 cycle in WAIT_END, then DONE).

Source files
------------

// File: rtl/rsnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsnn_pkg
// Description : Shared types and default constants for the RSNN parameter
//               serial-load transmitter: FSM state encoding, default word
//               width / acknowledge timeout, and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rsnn_pkg;

    localparam int RSNN_PARAM_WORD_W = 8;
    localparam int RSNN_ACK_TIMEOUT  = 64;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHIFT    = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_WAIT_END = 3'd3,
        S_DONE     = 3'd4,
        S_ERROR    = 3'd5
    } ser_state_t;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rsnn_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : rsnn_timeout_ctr
// Description : Saturating up-counter used as the acknowledge watchdog.
//               'expired' is high once LIMIT-1 counted cycles have elapsed;
//               the count then sticks there until 'clear'.
// Ports       : clk, reset (async, active-high)
//               clear   - synchronous restart to zero (wins over en)
//               en      - count one cycle
//               expired - count has reached LIMIT-1
// Revision    : 1.0 - initial release
// ============================================================================
module rsnn_timeout_ctr
    import rsnn_pkg::*;
#(
    parameter int LIMIT = RSNN_ACK_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int            CW    = cnt_width(LIMIT);
    localparam logic [CW-1:0] C_MAX = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != C_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == C_MAX);

endmodule
`default_nettype wire

// File: rtl/rsnn_param_serializer.sv
`default_nettype none
// ============================================================================
// Module      : rsnn_param_serializer
// Description : Host-side transmitter for the RSNN serial parameter-load
//               port. Accepts words on a valid/ready stream, shifts them out
//               MSB-first on load_params/data_out, waits for the per-word
//               data_written acknowledge and, after the last word, for
//               end_writing. Reports done (pulse) or error (sticky timeout).
// Ports       : clk, reset (async, active-high), enable
//               word_valid/word_data/word_last/word_ready - input stream
//               load_params/data_out - serial strobe and bit to the core
//               data_written/end_writing - acknowledges from the core
//               busy/done/error - status
// Revision    : 1.0 - initial release
// ============================================================================
module rsnn_param_serializer
    import rsnn_pkg::*;
#(
    parameter int WORD_W      = RSNN_PARAM_WORD_W,
    parameter int ACK_TIMEOUT = RSNN_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_last,
    output logic              word_ready,
    output logic              load_params,
    output logic              data_out,
    input  logic              data_written,
    input  logic              end_writing,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int            BW         = cnt_width(WORD_W + 1);
    localparam logic [BW-1:0] C_LAST_BIT = BW'(WORD_W - 1);

    ser_state_t        state;
    logic [WORD_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic              last_flag;

    logic [WORD_W-1:0] shreg_next;
    logic              bit_last;
    logic              tmo_clear;
    logic              tmo_en;
    logic              tmo_expired;

    assign shreg_next = shreg << 1;
    assign bit_last   = (bit_cnt == C_LAST_BIT);

    // The watchdog restarts whenever a wait state is entered and only runs
    // while enabled in a wait state.
    assign tmo_clear = ((state == S_SHIFT) && load_params && bit_last) ||
                       (enable && (state == S_WAIT_ACK) && data_written && last_flag);
    assign tmo_en    = enable && ((state == S_WAIT_ACK) || (state == S_WAIT_END));

    rsnn_timeout_ctr #(
        .LIMIT (ACK_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            last_flag   <= 1'b0;
            word_ready  <= 1'b1;
            load_params <= 1'b0;
            data_out    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // word_ready is registered and already promised, so a
                    // word offered while disabled is still taken; the
                    // strobe simply stays low until enable returns.
                    if (word_valid && word_ready) begin
                        shreg       <= word_data;
                        last_flag   <= word_last;
                        bit_cnt     <= '0;
                        error       <= 1'b0;
                        word_ready  <= 1'b0;
                        busy        <= 1'b1;
                        data_out    <= word_data[WORD_W-1];
                        load_params <= enable;
                        state       <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    // data_out always mirrors shreg MSB. A bit is retired on
                    // every edge where the strobe was high, because the core
                    // sampled it there; this keeps the stream gap-free and
                    // duplicate-free across an enable pause.
                    if (load_params) begin
                        shreg   <= shreg_next;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_last) begin
                            load_params <= 1'b0;
                            data_out    <= 1'b0;
                            state       <= S_WAIT_ACK;
                        end else begin
                            data_out    <= shreg_next[WORD_W-1];
                            load_params <= enable;
                        end
                    end else if (enable) begin
                        load_params <= 1'b1;
                    end
                end

                S_WAIT_ACK: begin
                    if (enable) begin
                        if (data_written) begin
                            if (last_flag) begin
                                state <= S_WAIT_END;
                            end else begin
                                word_ready <= 1'b1;
                                busy       <= 1'b0;
                                state      <= S_IDLE;
                            end
                        end else if (tmo_expired) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_ERROR;
                        end
                    end
                end

                S_WAIT_END: begin
                    if (enable) begin
                        if (end_writing) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else if (tmo_expired) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_ERROR;
                        end
                    end
                end

                S_DONE: begin
                    if (enable) begin
                        done       <= 1'b0;
                        word_ready <= 1'b1;
                        state      <= S_IDLE;
                    end
                end

                S_ERROR: begin
                    // error was raised on entry so it coincides with busy
                    // falling; the host restarts the image from word 0.
                    if (enable) begin
                        word_ready <= 1'b1;
                        state      <= S_IDLE;
                    end
                end

                default: begin
                    word_ready  <= 1'b1;
                    load_params <= 1'b0;
                    data_out    <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rsnn_param_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsnn_param_serializer
// Description : Self-checking bench for rsnn_param_serializer. Stimulus
//               pushes expected strobed bits and expected done/error events
//               into queues; a negedge monitor pops and compares them.
//               Cycle-exact status checks are made inline by the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsnn_param_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         word_valid;
    logic [W-1:0] word_data;
    logic         word_last;
    logic         word_ready;
    logic         load_params;
    logic         data_out;
    logic         data_written;
    logic         end_writing;
    logic         busy;
    logic         done;
    logic         error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hs_cyc = 0;
    int hs_prev;

    bit exp_bits[$];
    int exp_ev[$];          // 1 = done pulse, 2 = error rising
    logic prev_err = 1'b0;

    rsnn_param_serializer #(
        .WORD_W      (W),
        .ACK_TIMEOUT (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .word_valid   (word_valid),
        .word_data    (word_data),
        .word_last    (word_last),
        .word_ready   (word_ready),
        .load_params  (load_params),
        .data_out     (data_out),
        .data_written (data_written),
        .end_writing  (end_writing),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Handshake in the current cycle (cycle 0); returns in cycle 1.
    // nbits = how many MSB-first bits the core is expected to receive.
    task automatic send_word(input logic [W-1:0] d, input logic last, input int nbits);
        for (int i = W - 1; i > W - 1 - nbits; i--) exp_bits.push_back(d[i]);
        check_bit("ready_in_idle", word_ready, 1'b1);
        word_data  = d;
        word_last  = last;
        word_valid = 1'b1;
        hs_prev    = hs_cyc;
        hs_cyc     = cyc;
        tick(1);
        word_valid = 1'b0;
        check_bit("ready_low_shift", word_ready, 1'b0);
        check_bit("busy_shift", busy, 1'b1);
    endtask

    // From cycle 1: runs the shift, waits ack_wait WAIT_ACK cycles, then
    // pulses data_written for one cycle. Returns the cycle after the ack.
    task automatic finish_word(input int ack_wait);
        tick(7);
        check_bit("strobe_last_bit", load_params, 1'b1);
        tick(1);
        check_bit("strobe_off_ack", load_params, 1'b0);
        check_bit("ready_low_ack", word_ready, 1'b0);
        tick(ack_wait);
        data_written = 1'b1;
        tick(1);
        data_written = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (load_params) begin
                if (exp_bits.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got bit %b expected none (cycle %0d)", data_out, cyc);
                end else begin
                    check_bit("strobe_bit", data_out, exp_bits.pop_front());
                end
            end
            if (done) begin
                if (exp_ev.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done expected none (cycle %0d)", cyc);
                end else begin
                    check_int("event_done", 1, exp_ev.pop_front());
                end
            end
            if (error && !prev_err) begin
                if (exp_ev.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_error: got error expected none (cycle %0d)", cyc);
                end else begin
                    check_int("event_error", 2, exp_ev.pop_front());
                end
            end
        end
        prev_err <= error;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        enable       = 1'b1;
        word_valid   = 1'b0;
        word_data    = '0;
        word_last    = 1'b0;
        data_written = 1'b0;
        end_writing  = 1'b0;
        tick(2);
        check_bit("rst_word_ready", word_ready, 1'b1);
        check_bit("rst_load_params", load_params, 1'b0);
        check_bit("rst_data_out", data_out, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_error", error, 1'b0);
        reset = 1'b0;
        tick(2);

        // ---- single word 0xA5, ack at cycle 10, end_writing at cycle 12
        send_word(8'hA5, 1'b1, 8);
        finish_word(1);                 // now cycle 11, WAIT_END
        check_bit("t1_done_early", done, 1'b0);
        check_bit("t1_busy_wait_end", busy, 1'b1);
        tick(1);                        // cycle 12
        end_writing = 1'b1;
        exp_ev.push_back(1);
        tick(1);                        // cycle 13
        check_bit("t1_done", done, 1'b1);
        check_bit("t1_busy_fall", busy, 1'b0);
        check_bit("t1_error", error, 1'b0);
        end_writing = 1'b0;
        tick(1);
        check_bit("t1_done_pulse_end", done, 1'b0);
        tick(1);

        // ---- three words back to back, immediate acks
        send_word(8'h01, 1'b0, 8);
        finish_word(0);
        send_word(8'hFF, 1'b0, 8);
        check_int("t2_gap_w2", hs_cyc - hs_prev, 10);
        finish_word(0);
        send_word(8'h80, 1'b0, 8);
        check_int("t2_gap_w3", hs_cyc - hs_prev, 10);
        finish_word(0);
        check_bit("t2_idle_ready", word_ready, 1'b1);
        check_bit("t2_idle_busy", busy, 1'b0);
        tick(1);

        // ---- ack timeout after 0x3C
        send_word(8'h3C, 1'b0, 8);
        tick(8);                        // cycle 9, first WAIT_ACK cycle
        tick(63);                       // cycle 72, 64th WAIT_ACK cycle
        check_bit("t3_error_early", error, 1'b0);
        check_bit("t3_busy_waiting", busy, 1'b1);
        exp_ev.push_back(2);
        tick(1);
        check_bit("t3_error_set", error, 1'b1);
        check_bit("t3_busy_fall", busy, 1'b0);
        tick(1);
        check_bit("t3_ready_after_err", word_ready, 1'b1);
        check_bit("t3_error_sticky", error, 1'b1);
        send_word(8'h12, 1'b0, 8);
        check_bit("t3_error_cleared", error, 1'b0);
        finish_word(0);
        tick(1);

        // ---- enable pause during bit 3 of 0xC3, then pause during WAIT_ACK
        send_word(8'hC3, 1'b0, 8);
        tick(2);                        // cycle 3, bit 3 on the wire
        check_bit("t4_strobe_bit3", load_params, 1'b1);
        enable = 1'b0;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            check_bit("t4_strobe_paused", load_params, 1'b0);
            tick(1);
        end
        enable = 1'b1;                  // cycle 8
        check_bit("t4_strobe_resume_lag", load_params, 1'b0);
        tick(1);
        check_bit("t4_strobe_resumed", load_params, 1'b1);
        tick(5);                        // cycle 14, first WAIT_ACK cycle
        check_bit("t4_in_wait_ack", load_params, 1'b0);
        tick(40);
        enable = 1'b0;
        tick(10);
        enable = 1'b1;
        tick(23);                       // 63 enabled WAIT_ACK cycles so far
        check_bit("t4_no_timeout", error, 1'b0);
        data_written = 1'b1;
        tick(1);
        data_written = 1'b0;
        check_bit("t4_error_after_ack", error, 1'b0);
        check_bit("t4_ready_after_ack", word_ready, 1'b1);
        check_bit("t4_busy_after_ack", busy, 1'b0);
        tick(1);

        // ---- asynchronous reset during bit 5 of 0x5F
        send_word(8'h5F, 1'b0, 4);
        tick(4);                        // cycle 5, bit 5 (=1) on the wire
        check_bit("t5_strobe_before", load_params, 1'b1);
        check_bit("t5_data_before", data_out, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_bit("t5_rst_strobe", load_params, 1'b0);
        check_bit("t5_rst_data", data_out, 1'b0);
        check_bit("t5_rst_ready", word_ready, 1'b1);
        check_bit("t5_rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(1);
        check_bit("t5_idle_ready", word_ready, 1'b1);
        check_bit("t5_idle_strobe", load_params, 1'b0);

        // ---- end_writing already high before the last ack; stray ack in SHIFT
        end_writing = 1'b1;
        send_word(8'h96, 1'b1, 8);
        tick(1);
        data_written = 1'b1;            // ignored outside WAIT_ACK
        tick(1);
        data_written = 1'b0;
        tick(6);                        // cycle 9
        exp_ev.push_back(1);
        data_written = 1'b1;
        tick(1);                        // cycle 10, WAIT_END
        data_written = 1'b0;
        check_bit("t6_done_wait_end", done, 1'b0);
        check_bit("t6_busy_wait_end", busy, 1'b1);
        tick(1);                        // cycle 11, DONE
        check_bit("t6_done", done, 1'b1);
        check_bit("t6_busy_fall", busy, 1'b0);
        tick(1);
        check_bit("t6_done_end", done, 1'b0);
        check_bit("t6_ready", word_ready, 1'b1);
        end_writing = 1'b0;

        tick(3);
        check_int("leftover_bits", exp_bits.size(), 0);
        check_int("leftover_events", exp_ev.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
